// File: rtl/ad9833_pkg.sv
// Shared constants and types for the AD9833 receive-side decoder.
// Address map, control bit positions, FSM encoding and shadow register file.
package ad9833_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'b00;
    localparam logic [1:0] ADDR_FREQ0 = 2'b01;
    localparam logic [1:0] ADDR_FREQ1 = 2'b10;
    localparam logic [1:0] ADDR_PHASE = 2'b11;

    localparam int B28     = 13;
    localparam int HLB     = 12;
    localparam int FSELECT = 11;
    localparam int PSELECT = 10;
    localparam int RESET   = 8;

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    typedef struct packed {
        logic [13:0] control;
        logic [27:0] freq0;
        logic [27:0] freq1;
        logic [11:0] phase0;
        logic [11:0] phase1;
    } ad9833_regs_t;

endpackage

// File: rtl/ad9833_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin.
// A history flop behind the chain yields registered-level fall/rise strobes.
module ad9833_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], i_pin};
        hist_d  = chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q  <= RESET_VAL;
        end else begin
            chain_q <= chain_d;
            hist_q  <= hist_d;
        end
    end

    assign o_level = chain_q[SYNC_STAGES-1];
    assign o_fall  = hist_q & ~o_level;
    assign o_rise  = ~hist_q & o_level;

endmodule

// File: rtl/ad9833_rx_decoder.sv
// AD9833 three-wire write monitor: deserialises fsync/sclk/sdata frames
// and mirrors them into a shadow control/frequency/phase register file.
module ad9833_rx_decoder
    import ad9833_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fsync,
    input  logic        i_sclk,
    input  logic        i_sdata,
    output logic [15:0] o_word,
    output logic        o_word_valid,
    output logic [13:0] o_control,
    output logic [27:0] o_freq0,
    output logic [27:0] o_freq1,
    output logic [11:0] o_phase0,
    output logic [11:0] o_phase1,
    output logic        o_freq_update,
    output logic        o_frame_err
);

    localparam logic [4:0] WORD_CNT   = 5'(WORD_BITS);
    localparam logic [7:0] SETTLE_CNT = 8'(SYNC_STAGES + 1);

    logic fsync_lvl;
    logic fsync_fall_unused;
    logic fsync_rise_unused;
    logic sclk_lvl_unused;
    logic sclk_fall;
    logic sclk_rise_unused;
    logic sdata_lvl;
    logic sdata_fall_unused;
    logic sdata_rise_unused;

    ad9833_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_sync_fsync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_pin  (i_fsync),
        .o_level(fsync_lvl),
        .o_fall (fsync_fall_unused),
        .o_rise (fsync_rise_unused)
    );

    ad9833_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_sync_sclk (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_pin  (i_sclk),
        .o_level(sclk_lvl_unused),
        .o_fall (sclk_fall),
        .o_rise (sclk_rise_unused)
    );

    ad9833_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b0)
    ) u_sync_sdata (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_pin  (i_sdata),
        .o_level(sdata_lvl),
        .o_fall (sdata_fall_unused),
        .o_rise (sdata_rise_unused)
    );

    logic [1:0]   state_q,       state_d;
    logic [4:0]   cnt_q,         cnt_d;
    logic [7:0]   settle_q,      settle_d;
    logic [15:0]  sr_q,          sr_d;
    logic [15:0]  word_q,        word_d;
    logic         word_valid_q,  word_valid_d;
    logic         freq_update_q, freq_update_d;
    logic         frame_err_q,   frame_err_d;
    ad9833_regs_t regs_q,        regs_d;
    logic [13:0]  lsb_q,         lsb_d;
    logic         pend_q,        pend_d;
    logic         pend_sel_q,    pend_sel_d;

    logic         commit;
    logic [1:0]   addr;
    logic [13:0]  data;
    logic         fsel;
    logic [27:0]  fbase;
    logic [27:0]  fval;
    logic         fwrite;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        settle_d      = settle_q;
        sr_d          = sr_q;
        word_d        = word_q;
        word_valid_d  = 1'b0;
        freq_update_d = 1'b0;
        frame_err_d   = 1'b0;
        regs_d        = regs_q;
        lsb_d         = lsb_q;
        pend_d        = pend_q;
        pend_sel_d    = pend_sel_q;
        commit        = 1'b0;
        addr          = sr_q[15:14];
        data          = sr_q[13:0];
        fsel          = (sr_q[15:14] == ADDR_FREQ1);
        fbase         = fsel ? regs_q.freq1 : regs_q.freq0;
        fval          = fbase;
        fwrite        = 1'b0;

        unique case (state_q)
            // The synchroniser presets read as idle-high, so hold off
            // until the chain reflects the real pin before trusting fsync.
            ST_WAIT_IDLE: begin
                if (settle_q != SETTLE_CNT) begin
                    settle_d = settle_q + 8'd1;
                end else if (fsync_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!fsync_lvl) begin
                    cnt_d   = 5'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == WORD_CNT) begin
                    word_d       = sr_q;
                    word_valid_d = 1'b1;
                    commit       = 1'b1;
                    state_d      = ST_DONE;
                end else if (fsync_lvl) begin
                    frame_err_d = (cnt_q != 5'd0);
                    state_d     = ST_IDLE;
                end else if (sclk_fall) begin
                    sr_d  = {sr_q[14:0], sdata_lvl};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (fsync_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        if (commit) begin
            unique case (1'b1)
                addr == ADDR_CTRL: begin
                    regs_d.control = data;
                    pend_d         = 1'b0;
                end
                addr == ADDR_PHASE: begin
                    if (data[13]) begin
                        regs_d.phase1 = data[11:0];
                    end else begin
                        regs_d.phase0 = data[11:0];
                    end
                end
                addr != ADDR_CTRL && addr != ADDR_PHASE
                    && regs_q.control[B28]: begin
                    if (pend_q && pend_sel_q == fsel) begin
                        fval   = {data, lsb_q};
                        fwrite = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        lsb_d      = data;
                        pend_d     = 1'b1;
                        pend_sel_d = fsel;
                    end
                end
                addr != ADDR_CTRL && addr != ADDR_PHASE
                    && !regs_q.control[B28]: begin
                    if (regs_q.control[HLB]) begin
                        fval = {data, fbase[13:0]};
                    end else begin
                        fval = {fbase[27:14], data};
                    end
                    fwrite = 1'b1;
                end
            endcase
        end

        if (fwrite) begin
            freq_update_d = 1'b1;
            if (fsel) begin
                regs_d.freq1 = fval;
            end else begin
                regs_d.freq0 = fval;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_WAIT_IDLE;
            cnt_q         <= '0;
            settle_q      <= '0;
            sr_q          <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            freq_update_q <= 1'b0;
            frame_err_q   <= 1'b0;
            regs_q        <= '0;
            lsb_q         <= '0;
            pend_q        <= 1'b0;
            pend_sel_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            settle_q      <= settle_d;
            sr_q          <= sr_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            freq_update_q <= freq_update_d;
            frame_err_q   <= frame_err_d;
            regs_q        <= regs_d;
            lsb_q         <= lsb_d;
            pend_q        <= pend_d;
            pend_sel_q    <= pend_sel_d;
        end
    end

    assign o_word        = word_q;
    assign o_word_valid  = word_valid_q;
    assign o_control     = regs_q.control;
    assign o_freq0       = regs_q.freq0;
    assign o_freq1       = regs_q.freq1;
    assign o_phase0      = regs_q.phase0;
    assign o_phase1      = regs_q.phase1;
    assign o_freq_update = freq_update_q;
    assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_ad9833_rx_decoder.sv
// Bench for ad9833_rx_decoder: directed vector table, corner sequences
// and randomised frames checked against an arithmetic register model.
module tb_ad9833_rx_decoder;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fsync = 1'b1;
    logic        sclk = 1'b1;
    logic        sdata = 1'b0;
    logic [15:0] o_word;
    logic        o_word_valid;
    logic [13:0] o_control;
    logic [27:0] o_freq0;
    logic [27:0] o_freq1;
    logic [11:0] o_phase0;
    logic [11:0] o_phase1;
    logic        o_freq_update;
    logic        o_frame_err;

    always #5 clk = ~clk;

    ad9833_rx_decoder #(
        .SYNC_STAGES(SS),
        .WORD_BITS  (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fsync      (fsync),
        .i_sclk       (sclk),
        .i_sdata      (sdata),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .o_control    (o_control),
        .o_freq0      (o_freq0),
        .o_freq1      (o_freq1),
        .o_phase0     (o_phase0),
        .o_phase1     (o_phase1),
        .o_freq_update(o_freq_update),
        .o_frame_err  (o_frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_wv = 0;
    int n_fu = 0;
    int n_err = 0;
    int last_valid_cyc = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_word_valid) begin
            n_wv <= n_wv + 1;
            last_valid_cyc <= cyc;
        end
        if (o_freq_update) n_fu <= n_fu + 1;
        if (o_frame_err) n_err <= n_err + 1;
    end

    // Reference model: register file as plain integers.
    int m_word, m_ctrl, m_f0, m_f1, m_p0, m_p1;
    int m_pend, m_pend_sel, m_lsb;
    int e_wv = 0;
    int e_fu = 0;
    int e_err = 0;

    function automatic void model_reset();
        m_word = 0; m_ctrl = 0; m_f0 = 0; m_f1 = 0;
        m_p0 = 0; m_p1 = 0; m_pend = 0; m_pend_sel = 0; m_lsb = 0;
    endfunction

    function automatic void model_frame(input logic [31:0] bits, input int n);
        int w, top, d, sel, old, nv;
        if (n < 16) begin
            if (n > 0) e_err++;
            return;
        end
        w = int'(bits >> (n - 16)) & 'hFFFF;
        e_wv++;
        m_word = w;
        top = w / 16384;
        d = w % 16384;
        if (top == 0) begin
            m_ctrl = d;
            m_pend = 0;
        end else if (top == 3) begin
            if (d >= 8192) m_p1 = d % 4096;
            else m_p0 = d % 4096;
        end else begin
            sel = top - 1;
            if ((m_ctrl / 8192) % 2 == 1) begin
                if (m_pend == 1 && m_pend_sel == sel) begin
                    nv = d * 16384 + m_lsb;
                    if (sel == 1) m_f1 = nv; else m_f0 = nv;
                    e_fu++;
                    m_pend = 0;
                end else begin
                    m_pend = 1;
                    m_pend_sel = sel;
                    m_lsb = d;
                end
            end else begin
                old = (sel == 1) ? m_f1 : m_f0;
                if ((m_ctrl / 4096) % 2 == 1) nv = d * 16384 + old % 16384;
                else nv = (old / 16384) * 16384 + d;
                if (sel == 1) m_f1 = nv; else m_f0 = nv;
                e_fu++;
            end
        end
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm);
        cmp({nm, ".word"}, o_word, m_word);
        cmp({nm, ".ctrl"}, o_control, m_ctrl);
        cmp({nm, ".f0"}, o_freq0, m_f0);
        cmp({nm, ".f1"}, o_freq1, m_f1);
        cmp({nm, ".p0"}, o_phase0, m_p0);
        cmp({nm, ".p1"}, o_phase1, m_p1);
        cmp({nm, ".n_wv"}, n_wv, e_wv);
        cmp({nm, ".n_fu"}, n_fu, e_fu);
        cmp({nm, ".n_err"}, n_err, e_err);
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, ".word"}, o_word, 0);
        cmp({nm, ".wv"}, o_word_valid, 0);
        cmp({nm, ".ctrl"}, o_control, 0);
        cmp({nm, ".f0"}, o_freq0, 0);
        cmp({nm, ".f1"}, o_freq1, 0);
        cmp({nm, ".p0"}, o_phase0, 0);
        cmp({nm, ".p1"}, o_phase1, 0);
        cmp({nm, ".fu"}, o_freq_update, 0);
        cmp({nm, ".err"}, o_frame_err, 0);
    endtask

    task automatic sclk_bit(input logic b, input logic clash);
        sdata = b;
        repeat (2) @(negedge clk);
        sclk = 1'b0;
        fall_cyc = cyc;
        if (clash) fsync = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n,
                              input logic clash);
        @(negedge clk);
        fsync = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            sclk_bit(bits[n-1-i], clash && (i == n - 1));
        end
        repeat (4) @(negedge clk);
        fsync = 1'b1;
        repeat (6) @(negedge clk);
        model_frame(bits, clash ? n - 1 : n);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [13:0] ctrl;
        logic [27:0] f0;
        logic [27:0] f1;
        logic [11:0] p0;
        logic [11:0] p1;
        int          fu;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int wv0, fu0, err0, lat, n, r;
        logic [31:0] bits;
        logic [15:0] w;

        vecs[0]  = '{16'h2000, 14'h2000, 28'h0, 28'h0, 12'h0, 12'h0, 0};
        vecs[1]  = '{16'h400F, 14'h2000, 28'h0, 28'h0, 12'h0, 12'h0, 0};
        vecs[2]  = '{16'h4000, 14'h2000, 28'hF, 28'h0, 12'h0, 12'h0, 1};
        vecs[3]  = '{16'h1000, 14'h1000, 28'hF, 28'h0, 12'h0, 12'h0, 0};
        vecs[4]  = '{16'h8123, 14'h1000, 28'hF, 28'h48C000, 12'h0, 12'h0, 1};
        vecs[5]  = '{16'hC5A5, 14'h1000, 28'hF, 28'h48C000, 12'h5A5, 12'h0, 0};
        vecs[6]  = '{16'hE7FF, 14'h1000, 28'hF, 28'h48C000, 12'h5A5, 12'h7FF, 0};
        vecs[7]  = '{16'h0000, 14'h0000, 28'hF, 28'h48C000, 12'h5A5, 12'h7FF, 0};
        vecs[8]  = '{16'h4ABC, 14'h0000, 28'hABC, 28'h48C000, 12'h5A5, 12'h7FF, 1};
        vecs[9]  = '{16'h2000, 14'h2000, 28'hABC, 28'h48C000, 12'h5A5, 12'h7FF, 0};
        vecs[10] = '{16'h8005, 14'h2000, 28'hABC, 28'h48C000, 12'h5A5, 12'h7FF, 0};
        vecs[11] = '{16'h4007, 14'h2000, 28'hABC, 28'h48C000, 12'h5A5, 12'h7FF, 0};
        vecs[12] = '{16'h4001, 14'h2000, 28'h4007, 28'h48C000, 12'h5A5, 12'h7FF, 1};
        vecs[13] = '{16'h0100, 14'h0100, 28'h4007, 28'h48C000, 12'h5A5, 12'h7FF, 0};

        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_zero("post_reset");

        for (int i = 0; i < 14; i++) begin
            wv0 = n_wv;
            fu0 = n_fu;
            send_frame({16'h0, vecs[i].word}, 16, 1'b0);
            cmp($sformatf("vec%0d.word", i), o_word, vecs[i].word);
            cmp($sformatf("vec%0d.ctrl", i), o_control, vecs[i].ctrl);
            cmp($sformatf("vec%0d.f0", i), o_freq0, vecs[i].f0);
            cmp($sformatf("vec%0d.f1", i), o_freq1, vecs[i].f1);
            cmp($sformatf("vec%0d.p0", i), o_phase0, vecs[i].p0);
            cmp($sformatf("vec%0d.p1", i), o_phase1, vecs[i].p1);
            cmp($sformatf("vec%0d.wv", i), n_wv - wv0, 1);
            cmp($sformatf("vec%0d.fu", i), n_fu - fu0, vecs[i].fu);
        end
        check_all("table");
        cmp("table.err", n_err, 0);

        lat = last_valid_cyc - fall_cyc;
        cmp("latency", lat, SS + 2);

        err0 = n_err;
        wv0 = n_wv;
        send_frame(32'h3FF, 10, 1'b0);
        cmp("short.err", n_err - err0, 1);
        cmp("short.wv", n_wv - wv0, 0);
        send_frame(32'h0AAA, 16, 1'b0);
        cmp("after_short.ctrl", o_control, 14'h0AAA);
        check_all("short");

        err0 = n_err;
        send_frame(32'h0123B, 20, 1'b0);
        cmp("long.ctrl", o_control, 14'h0123);
        cmp("long.err", n_err - err0, 0);
        check_all("long");

        err0 = n_err;
        send_frame(32'h0, 0, 1'b0);
        cmp("empty.err", n_err - err0, 0);

        err0 = n_err;
        wv0 = n_wv;
        send_frame(32'hC777, 16, 1'b1);
        cmp("clash.err", n_err - err0, 1);
        cmp("clash.wv", n_wv - wv0, 0);
        check_all("clash");

        send_frame(32'h2000, 16, 1'b0);
        send_frame(32'h4005, 16, 1'b0);
        @(negedge clk);
        fsync = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) sclk_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("mid_reset");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) sclk_bit(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        fsync = 1'b1;
        repeat (6) @(negedge clk);
        check_all("after_partial");
        send_frame(32'hC123, 16, 1'b0);
        cmp("after_partial.p0", o_phase0, 12'h123);
        check_all("rst_next");

        for (int k = 0; k < 50; k++) begin
            w = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7) begin
                n = 16;
                bits = {16'h0, w};
            end else if (r == 7) begin
                n = $urandom_range(0, 15);
                bits = 32'($urandom) & ((32'd1 << n) - 32'd1);
            end else begin
                n = $urandom_range(17, 20);
                bits = (32'(w) << (n - 16))
                     | (32'($urandom) & ((32'd1 << (n - 16)) - 32'd1));
            end
            send_frame(bits, n, 1'b0);
            check_all($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ad9833_rx_decoder.md
Name: ad9833_rx_decoder

Overview:
Receive-side counterpart of the AD9833 three-wire write interface (fsync, sclk, sdata) driven by the team's AD9833 transmitter.
- Oversamples the three pins in the system clock domain.
- Deserialises 16-bit MSB-first words sampled on sclk falling edges while fsync is low.
- Decodes each word into a shadow AD9833 register file (control, FREQ0/1, PHASE0/1).
- Used as a loopback checker and bench/board monitor for the DDS programming path.

Parameters:
SYNC_STAGES, 2, flip-flop stages per pin synchroniser (minimum 2).
WORD_BITS, 16, bits per frame; fixed by protocol, exposed for the bench only.

Ports:
i_clk  in  1  system clock; must be at least 4x the sclk frequency.
i_rst_n  in  1  asynchronous active-low reset.
i_fsync  in  1  frame sync, active low, asynchronous to i_clk.
i_sclk  in  1  serial clock; data sampled on its falling edge.
i_sdata  in  1  serial data, MSB first.
o_word  out  16  last complete raw word.
o_word_valid  out  1  one-cycle pulse when o_word updates.
o_control  out  14  control register D13..D0.
o_freq0  out  28  FREQ0 shadow register.
o_freq1  out  28  FREQ1 shadow register.
o_phase0  out  12  PHASE0 shadow register.
o_phase1  out  12  PHASE1 shadow register.
o_freq_update  out  1  one-cycle pulse when a full 28-bit frequency value commits (either register).
o_frame_err  out  1  one-cycle pulse when fsync rises with 1..15 bits received.

Behaviour:
Reset values:
- All outputs are 0.
- Synchroniser chains preset to idle-high for fsync and sclk.
- State goes to WAIT_IDLE.

Front end:
- Each pin passes through SYNC_STAGES flops, plus one history flop for edge detection.
- Falling edge of sclk: synced value 0, previous value 1.
- Latency: o_word_valid rises SYNC_STAGES+2 i_clk cycles after the 16th pin-level falling sclk edge.

FSM:
- WAIT_IDLE: wait for synced fsync high, then go to IDLE. This prevents capturing a frame that was already in progress when reset released.
- IDLE: on fsync low, clear bit counter and go to SHIFT.
- SHIFT: on each sclk falling edge, shift sdata into a 16-bit register and increment a 5-bit counter.
  - At count 16: latch o_word, pulse o_word_valid, decode, go to DONE.
  - On fsync high before count 16: if count is 1..15, pulse o_frame_err; if count is 0, no error. Discard the frame and go to IDLE.
- DONE: ignore further sclk edges; go to IDLE on fsync high.
- A falling sclk edge and a rising fsync in the same cycle: fsync wins; the edge is not counted.

Decode, addressed by D15:D14:
- 00: o_control <= D13..D0. Clears the B28 pending flag.
- 01 / 10: frequency write to FREQ0 / FREQ1. Let ctl = o_control.
  - B28 = ctl[13] = 1:
    - First word: store D13..D0 as LSB, set pending with the target register.
    - Second word to the same register: commit {D13..D0, stored LSB} and pulse o_freq_update.
    - Second word to the other register: drops the old pending value and becomes the new pending LSB.
  - B28 = 0:
    - HLB = ctl[12] selects the half written: 1 writes [27:14], 0 writes [13:0]. The other half is unchanged.
    - Commits immediately and pulses o_freq_update.
- 11: phase write. D13 selects PHASE1 (1) or PHASE0 (0). Register <= D11..D0; D12 is ignored. Does not affect the pending flag.

Boundary conditions:
- The control reset bit (D8) is stored only; shadow registers are not cleared.
- Asynchronous reset mid-frame drops the partial word and the pending LSB.
- Back-to-back frames need only one synced fsync-high sample between them.

Decomposition:
- Package ad9833_pkg holds:
  - address constants ADDR_CTRL=2'b00, ADDR_FREQ0=2'b01, ADDR_FREQ1=2'b10, ADDR_PHASE=2'b11;
  - control bit indices B28=13, HLB=12, FSELECT=11, PSELECT=10, RESET=8;
  - FSM state encoding.
- One sub-module, ad9833_pin_sync: parameterised synchroniser plus a fall/rise edge detector, instantiated once per pin.

Test Plan:
- Control 16'h2000, then 16'h400F, then 16'h4000 -> o_control=14'h2000; o_freq0=28'h000000F; o_freq_update pulses only after the third word; three o_word_valid pulses.
- Control 16'h1000 (B28=0, HLB=1), then 16'h8123 -> o_freq1=28'h048C000 with [13:0] unchanged from 0; immediate o_freq_update.
- 16'hC5A5, then 16'hE7FF -> o_phase0=12'h5A5, o_phase1=12'h7FF; no o_freq_update.
- fsync low for 10 sclk edges, then high -> single o_frame_err pulse; no o_word_valid; the next full frame decodes correctly.
- 20 sclk edges in one fsync-low window carrying 16'h0123 then junk -> o_control=14'h0123; extra edges ignored; no error.
- Assert i_rst_n low mid-frame with fsync still low, release, then finish that frame -> nothing captured until fsync rises; the next frame decodes; all outputs were 0 during reset.
